// File: rtl/msg_framer_pkg.sv
// msg_framer_pkg: shared types and constants for the multi-channel message framer.
//   chan_state_e  - per-channel framing state (IDLE/HEAD/DATA/TAIL)
//   ERR_*         - err_code values reported on the err pulse
package msg_framer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HEAD = 2'b01,
        ST_DATA = 2'b10,
        ST_TAIL = 2'b11
    } chan_state_e;

    localparam logic [1:0] ERR_BAD_CH      = 2'b00;
    localparam logic [1:0] ERR_ORPHAN      = 2'b01;
    localparam logic [1:0] ERR_NESTED_HEAD = 2'b10;
    localparam logic [1:0] ERR_OVERFLOW    = 2'b11;

endpackage

// File: rtl/msg_chan_fsm.sv
// msg_chan_fsm: framing state machine and beat counter for one channel.
//   clock, reset_n : clock and asynchronous active-low reset
//   beat           : a valid beat addressed to this channel
//   head, tail     : beat framing flags
//   state, len     : current (registered) state and length
//   done, err, code: combinational completion/error indications for this beat
module msg_chan_fsm
    import msg_framer_pkg::*;
#(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             beat,
    input  logic             head,
    input  logic             tail,
    output chan_state_e      state,
    output logic [LEN_W-1:0] len,
    output logic             done,
    output logic             err,
    output logic [1:0]       code
);

    chan_state_e      state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        done    = 1'b0;
        err     = 1'b0;
        code    = ERR_BAD_CH;
        if (beat) begin
            if (head) begin
                // A head always starts a fresh message; inside an open one it
                // additionally flags the abandoned message.
                if (state_q == ST_HEAD || state_q == ST_DATA) begin
                    err  = 1'b1;
                    code = ERR_NESTED_HEAD;
                end
                len_d   = LEN_W'(1);
                state_d = tail ? ST_TAIL : ST_HEAD;
                done    = tail;
            end else begin
                unique case (state_q)
                    ST_HEAD, ST_DATA: begin
                        if (len_q == LEN_W'(MAX_LEN)) begin
                            err     = 1'b1;
                            code    = ERR_OVERFLOW;
                            state_d = ST_IDLE;
                            len_d   = '0;
                        end else begin
                            len_d   = len_q + LEN_W'(1);
                            state_d = tail ? ST_TAIL : ST_DATA;
                            done    = tail;
                        end
                    end
                    default: begin
                        err     = 1'b1;
                        code    = ERR_ORPHAN;
                        state_d = ST_IDLE;
                        len_d   = '0;
                    end
                endcase
            end
        end
    end

    assign state = state_q;
    assign len   = len_q;

endmodule

// File: rtl/msg_framer_mc.sv
// msg_framer_mc: multi-channel message framing checker.
//   clock, reset_n          : clock and asynchronous active-low reset
//   valid, head, tail, ch   : incoming beat and its channel
//   msg_ip                  : per-channel message-in-progress flags
//   done, done_ch, done_len : registered completion pulse with channel and length
//   err, err_ch, err_code   : registered framing-error pulse with channel and code
module msg_framer_mc
    import msg_framer_pkg::*;
#(
    parameter  int unsigned NUM_CH  = 4,
    parameter  int unsigned MAX_LEN = 16,
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              valid,
    input  logic              head,
    input  logic              tail,
    input  logic [CH_W-1:0]   ch,
    output logic [NUM_CH-1:0] msg_ip,
    output logic              done,
    output logic [CH_W-1:0]   done_ch,
    output logic [LEN_W-1:0]  done_len,
    output logic              err,
    output logic [CH_W-1:0]   err_ch,
    output logic [1:0]        err_code
);

    localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

    chan_state_e      chan_state [NUM_CH];
    logic [LEN_W-1:0] chan_len   [NUM_CH];
    logic [1:0]       chan_code  [NUM_CH];
    logic [NUM_CH-1:0] chan_done, chan_err;

    logic ch_ok;
    assign ch_ok = ({1'b0, ch} < NUM_CH_L);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        msg_chan_fsm #(
            .MAX_LEN (MAX_LEN),
            .LEN_W   (LEN_W)
        ) u_fsm (
            .clock   (clock),
            .reset_n (reset_n),
            .beat    (valid && (ch == CH_W'(g))),
            .head    (head),
            .tail    (tail),
            .state   (chan_state[g]),
            .len     (chan_len[g]),
            .done    (chan_done[g]),
            .err     (chan_err[g]),
            .code    (chan_code[g])
        );
        assign msg_ip[g] = (chan_state[g] == ST_HEAD) || (chan_state[g] == ST_DATA);
    end

    logic             done_d, err_d;
    logic [1:0]       code_d;
    logic             done_q, err_q;
    logic [CH_W-1:0]  done_ch_q, err_ch_q;
    logic [1:0]       err_code_q;

    // At most one channel is addressed per cycle, so OR-merging is a clean mux.
    always_comb begin
        done_d = 1'b0;
        err_d  = 1'b0;
        code_d = ERR_BAD_CH;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (chan_done[i]) done_d = 1'b1;
            if (chan_err[i]) begin
                err_d  = 1'b1;
                code_d = chan_code[i];
            end
        end
        if (valid && !ch_ok) begin
            err_d  = 1'b1;
            code_d = ERR_BAD_CH;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done_q     <= 1'b0;
            done_ch_q  <= '0;
            err_q      <= 1'b0;
            err_ch_q   <= '0;
            err_code_q <= '0;
        end else begin
            done_q     <= done_d;
            done_ch_q  <= done_d ? ch : '0;
            err_q      <= err_d;
            err_ch_q   <= err_d ? ch : '0;
            err_code_q <= err_d ? code_d : '0;
        end
    end

    // The completing channel's length register already holds the new length
    // for the whole pulse cycle, so it is selected instead of being copied.
    always_comb begin
        done_len = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (done_q && (done_ch_q == CH_W'(i))) done_len = chan_len[i];
        end
    end

    assign done     = done_q;
    assign done_ch  = done_ch_q;
    assign err      = err_q;
    assign err_ch   = err_ch_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_msg_framer_mc.sv
module tb_msg_framer_mc;

    localparam int NCH  = 5;   // CH_W=3, so channels 5..7 are addressable but illegal
    localparam int MAXL = 16;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       valid = 1'b0;
    logic       head = 1'b0;
    logic       tail = 1'b0;
    logic [2:0] ch = '0;
    logic [4:0] msg_ip;
    logic       done;
    logic [2:0] done_ch;
    logic [4:0] done_len;
    logic       err;
    logic [2:0] err_ch;
    logic [1:0] err_code;

    msg_framer_mc #(.NUM_CH(NCH), .MAX_LEN(MAXL)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .valid    (valid),
        .head     (head),
        .tail     (tail),
        .ch       (ch),
        .msg_ip   (msg_ip),
        .done     (done),
        .done_ch  (done_ch),
        .done_len (done_len),
        .err      (err),
        .err_ch   (err_ch),
        .err_code (err_code)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Message-level model: a channel is either open with a beat count, or not.
    bit open_m [NCH];
    int cnt_m  [NCH];
    bit e_done, e_err;
    int e_done_ch, e_done_len, e_err_ch, e_code;

    function automatic logic [19:0] pack_act();
        return {msg_ip, done, done_ch, done_len, err, err_ch, err_code};
    endfunction

    function automatic logic [19:0] pack_exp();
        logic [4:0] ip;
        for (int i = 0; i < NCH; i++) ip[i] = open_m[i];
        return {ip, e_done, 3'(e_done_ch), 5'(e_done_len), e_err, 3'(e_err_ch), 2'(e_code)};
    endfunction

    task automatic model_step();
        int c;
        e_done = 0; e_err = 0; e_done_ch = 0; e_done_len = 0; e_err_ch = 0; e_code = 0;
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin open_m[i] = 0; cnt_m[i] = 0; end
        end else if (valid) begin
            c = int'(ch);
            if (c >= NCH) begin
                e_err = 1; e_err_ch = c; e_code = 0;
            end else if (head) begin
                if (open_m[c]) begin e_err = 1; e_err_ch = c; e_code = 2; end
                cnt_m[c] = 1;
                open_m[c] = !tail;
                if (tail) begin e_done = 1; e_done_ch = c; e_done_len = 1; end
            end else if (!open_m[c]) begin
                e_err = 1; e_err_ch = c; e_code = 1;
            end else if (cnt_m[c] == MAXL) begin
                e_err = 1; e_err_ch = c; e_code = 3;
                open_m[c] = 0; cnt_m[c] = 0;
            end else begin
                cnt_m[c]++;
                if (tail) begin
                    e_done = 1; e_done_ch = c; e_done_len = cnt_m[c];
                    open_m[c] = 0;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clock or negedge reset_n);
        model_step();
    end

    initial forever begin
        @(negedge clock);
        if (chk_en) begin
            vectors++;
            if (pack_act() !== pack_exp()) begin
                miscompares++;
                $display("FAIL cycle_model t=%0t actual=%h required=%h", $time, pack_act(), pack_exp());
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic send(input bit h, input bit t, input int c);
        @(negedge clock);
        valid = 1'b1; head = h; tail = t; ch = 3'(c);
    endtask

    task automatic idle();
        @(negedge clock);
        valid = 1'b0; head = 1'b0; tail = 1'b0; ch = '0;
    endtask

    initial begin
        #3;
        chk("rst_all_zero", int'(pack_act()), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        chk_en = 1'b1;

        // Four-beat message on ch1
        send(1, 0, 1); send(0, 0, 1);
        chk("ip1_after_head", int'(msg_ip[1]), 1);
        send(0, 0, 1); send(0, 1, 1); idle();
        chk("m4_done", int'(done), 1);
        chk("m4_done_ch", int'(done_ch), 1);
        chk("m4_done_len", int'(done_len), 4);
        chk("m4_err", int'(err), 0);

        // Interleaved ch0/ch2
        send(1, 0, 0); send(1, 0, 2); send(0, 1, 0); send(0, 0, 2);
        chk("il_done_ch0", int'({done, done_ch, done_len}), {1'b1, 3'd0, 5'd2});
        send(0, 1, 2); idle();
        chk("il_done_ch2", int'({done, done_ch, done_len}), {1'b1, 3'd2, 5'd3});
        chk("il_no_err", int'(err), 0);

        // Exactly MAX_LEN beats completes; one more overflows
        send(1, 0, 4);
        repeat (14) send(0, 0, 4);
        send(0, 1, 4); idle();
        chk("max_len_done", int'(done_len), 16);
        send(1, 0, 0);
        repeat (16) send(0, 0, 0);
        idle();
        chk("ovf_err", int'({err, err_ch, err_code}), {1'b1, 3'd0, 2'b11});
        chk("ovf_ip0", int'(msg_ip[0]), 0);
        chk("ovf_no_done", int'(done), 0);

        // Nested head with head&tail on ch3
        send(1, 0, 3); send(0, 0, 3); send(1, 1, 3); idle();
        chk("nest_err", int'({err, err_ch, err_code}), {1'b1, 3'd3, 2'b10});
        chk("nest_done", int'({done, done_ch, done_len}), {1'b1, 3'd3, 5'd1});

        // Single-beat from TAIL, then orphan from TAIL, then orphan from IDLE
        send(1, 1, 3); send(0, 0, 3); send(0, 1, 0); idle();
        chk("orphan_ch0", int'({err, err_ch, err_code}), {1'b1, 3'd0, 2'b01});

        // Illegal channels leave state untouched
        send(1, 0, 1); send(0, 0, 5); idle();
        chk("badch", int'({err, err_ch, err_code}), {1'b1, 3'd5, 2'b00});
        chk("badch_ip", int'(msg_ip), 5'b00010);
        send(1, 1, 7); send(0, 1, 1); idle();
        chk("badch_keep_len", int'(done_len), 2);

        // Framing flags without valid are ignored
        @(negedge clock); head = 1'b1; tail = 1'b1; ch = 3'd2;
        idle();

        // Asynchronous reset mid-message on ch2
        send(1, 0, 2); send(0, 0, 2); send(0, 0, 0);
        @(posedge clock); #2;
        chk("pre_rst_err", int'(err), 1);
        chk("pre_rst_ip2", int'(msg_ip[2]), 1);
        valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("async_rst_zero", int'(pack_act()), 0);
        @(negedge clock); @(negedge clock);
        reset_n = 1'b1;
        send(0, 0, 2); idle();
        chk("post_rst_orphan", int'({err, err_ch, err_code}), {1'b1, 3'd2, 2'b01});
        repeat (2) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
